// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared types for the sram_accum block. It defines the
//               operation encodings and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    // Operation codes carried on op_code.
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_ACC   = 2'd1,
        OP_READ  = 2'd2,
        OP_RDCLR = 2'd3
    } op_t;

    // Controller state. INIT sweeps the array with RESET_VALUE.
    // RUN accepts operations.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_accum_array.sv
// ============================================================================
// Module      : sram_accum_array
// Description : Plain storage for sram_accum. It has one synchronous read port
//               and one write port. The contents are not reset.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address, sampled on the rising edge
//               o_rdata  - read data, valid the cycle after i_raddr is sampled
//                          (returns the old contents when a read and a write
//                          hit the same address in one cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_accum_array #(
    parameter int  WIDTH  = 32,
    parameter int  DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule : sram_accum_array

`default_nettype wire

// File: rtl/sram_accum.sv
// ============================================================================
// Module      : sram_accum
// Description : Word-addressed accumulator memory with an init sweep.
//               The op pipeline has three steps:
//                 - accept at cycle N
//                 - array read at N+1
//                 - compute, writeback and registered outputs at N+2
//               Back-to-back ops to the same word are forwarded, so the
//               results match sequential execution.
// Config      : SRAM_ACCUM_SAT_EN - when defined, OP_ACC clamps on overflow.
//               Otherwise OP_ACC wraps modulo 2^WIDTH.
//               ovf pulses on overflow in both cases.
// Ports       : clk, reset (async, active-high)
//               init_req          - restart the init sweep
//               op_valid/op_ready - operation handshake
//               op_code/op_addr/op_data - operation fields
//               rd_valid/rd_data  - read result; rd_data holds its value
//                                   between reads
//               ovf               - OP_ACC overflow pulse
//               busy              - init sweep in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_accum
    import sram_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 256,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              ADDR_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init_req,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  op_t                     op_code,
    input  logic [ADDR_W-1:0]       op_addr,
    input  logic signed [WIDTH-1:0] op_data,
    output logic                    rd_valid,
    output logic signed [WIDTH-1:0] rd_data,
    output logic                    ovf,
    output logic                    busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [WIDTH-1:0]  c_sat_max   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  c_sat_min   = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_sweep_addr;
    logic [ADDR_W-1:0]   w_sweep_addr_nxt;
    logic                w_sweep_we;

    // Pipeline registers
    logic                r_s1_valid;
    op_t                 r_s1_op;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [WIDTH-1:0]    r_s1_data;
    logic                r_s2_valid;
    op_t                 r_s2_op;
    logic [ADDR_W-1:0]   r_s2_addr;
    logic [WIDTH-1:0]    r_s2_data;

    // The most recent array write. It covers the read that coincided with it.
    logic                r_fwd_valid;
    logic [ADDR_W-1:0]   r_fwd_addr;
    logic [WIDTH-1:0]    r_fwd_data;

    logic                w_accept;
    logic [WIDTH-1:0]    w_mem_rdata;
    logic [WIDTH-1:0]    w_operand;
    logic [WIDTH:0]      w_sum;
    logic                w_sum_ovf;
    logic [WIDTH-1:0]    w_acc_result;
    logic                w_wb_we;
    logic [WIDTH-1:0]    w_wb_data;
    logic                w_rd_fire;
    logic                w_ovf_fire;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [WIDTH-1:0]    w_mem_wdata;

    assign op_ready = (r_state == ST_RUN);
    assign busy     = (r_state == ST_INIT);
    assign w_accept = op_valid && op_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_sweep_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_addr <= w_sweep_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sweep_addr_nxt = r_sweep_addr;
        w_sweep_we       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (init_req) begin
                    w_state_nxt      = ST_INIT;
                    w_sweep_addr_nxt = '0;
                end
            end
            ST_INIT: begin
                // Ops accepted before the sweep began still own the write
                // port. The sweep waits until they have retired, so they
                // cannot overwrite a word that was already swept.
                w_sweep_we = !reset && !r_s1_valid && !r_s2_valid;
                if (init_req) begin
                    w_sweep_addr_nxt = '0;
                end else if (w_sweep_we) begin
                    if (r_sweep_addr == c_last_addr) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_sweep_addr_nxt = r_sweep_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Execute stage (N+2)
    // ------------------------------------------------------------------
    // The read launched at N+1 cannot see a write made on the same edge.
    // Take the registered copy of that write instead.
    assign w_operand = (r_fwd_valid && (r_fwd_addr == r_s2_addr)) ? r_fwd_data
                                                                 : w_mem_rdata;

    assign w_sum     = {w_operand[WIDTH-1], w_operand} + {r_s2_data[WIDTH-1], r_s2_data};
    assign w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

`ifdef SRAM_ACCUM_SAT_EN
    // The sign of the wide result tells which limit was crossed.
    assign w_acc_result = w_sum_ovf ? (w_sum[WIDTH] ? c_sat_min : c_sat_max)
                                    : w_sum[WIDTH-1:0];
`else
    assign w_acc_result = w_sum[WIDTH-1:0];
`endif

    always_comb begin
        w_wb_we    = 1'b0;
        w_wb_data  = r_s2_data;
        w_rd_fire  = 1'b0;
        w_ovf_fire = 1'b0;
        if (r_s2_valid) begin
            case (r_s2_op)
                OP_WRITE: begin
                    w_wb_we   = 1'b1;
                    w_wb_data = r_s2_data;
                end
                OP_ACC: begin
                    w_wb_we    = 1'b1;
                    w_wb_data  = w_acc_result;
                    w_ovf_fire = w_sum_ovf;
                end
                OP_READ: begin
                    w_rd_fire = 1'b1;
                end
                OP_RDCLR: begin
                    w_rd_fire = 1'b1;
                    w_wb_we   = 1'b1;
                    w_wb_data = RESET_VALUE;
                end
                default: begin
                    w_wb_we = 1'b0;
                end
            endcase
        end
    end

    // Writeback and sweep never collide. The sweep only runs when stage 2
    // is empty.
    assign w_mem_we    = w_wb_we || w_sweep_we;
    assign w_mem_waddr = w_wb_we ? r_s2_addr : r_sweep_addr;
    assign w_mem_wdata = w_wb_we ? w_wb_data : RESET_VALUE;

    // ------------------------------------------------------------------
    // Pipeline and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_WRITE;
            r_s1_addr   <= '0;
            r_s1_data   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_op     <= OP_WRITE;
            r_s2_addr   <= '0;
            r_s2_data   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            ovf         <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op   <= op_code;
                r_s1_addr <= op_addr;
                r_s1_data <= op_data;
            end

            r_s2_valid <= r_s1_valid;
            r_s2_op    <= r_s1_op;
            r_s2_addr  <= r_s1_addr;
            r_s2_data  <= r_s1_data;

            r_fwd_valid <= w_mem_we;
            r_fwd_addr  <= w_mem_waddr;
            r_fwd_data  <= w_mem_wdata;

            rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                rd_data <= w_operand;
            end
            ovf <= w_ovf_fire;
        end
    end

    sram_accum_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (r_s1_addr),
        .o_rdata (w_mem_rdata)
    );

endmodule : sram_accum

`default_nettype wire

// File: tb/tb_sram_accum.sv
// ============================================================================
// Module      : tb_sram_accum
// Description : Directed self-checking bench for sram_accum. It uses
//               WIDTH=8, DEPTH=8 and RESET_VALUE=5.
//               The OP_ACC overflow expectations follow SRAM_ACCUM_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_accum;
    import sram_pkg::*;

    localparam int             WIDTH  = 8;
    localparam int             DEPTH  = 8;
    localparam int             ADDR_W = 3;
    localparam logic [WIDTH-1:0] RV   = 8'd5;

`ifdef SRAM_ACCUM_SAT_EN
    localparam int c_exp_pos_ovf = 127;
    localparam int c_exp_neg_ovf = -128;
`else
    localparam int c_exp_pos_ovf = -116;
    localparam int c_exp_neg_ovf = 116;
`endif

    logic                    clk      = 1'b0;
    logic                    reset    = 1'b1;
    logic                    init_req = 1'b0;
    logic                    op_valid = 1'b0;
    op_t                     op_code  = OP_WRITE;
    logic [ADDR_W-1:0]       op_addr  = '0;
    logic signed [WIDTH-1:0] op_data  = '0;
    logic                    op_ready;
    logic                    rd_valid;
    logic signed [WIDTH-1:0] rd_data;
    logic                    ovf;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rdq[$];
    int ovf_cnt  = 0;

    sram_accum #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .init_req (init_req),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_addr  (op_addr),
        .op_data  (op_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Collect read results and overflow pulses on the inactive edge.
    always @(negedge clk) begin
        if (rd_valid) rdq.push_back(int'(rd_data));
        if (ovf) ovf_cnt++;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t c, input int a, input int d);
        op_valid = 1'b1;
        op_code  = c;
        op_addr  = ADDR_W'(a);
        op_data  = WIDTH'(d);
        tick();
    endtask

    task automatic idle;
        op_valid = 1'b0;
    endtask

    task automatic wait_reads(input string tag, input int n);
        int t = 0;
        while (rdq.size() < n && t < 20) begin
            tick();
            t++;
        end
        check_val(tag, rdq.size(), n);
    endtask

    task automatic pop_check(input string tag, input int exp);
        int got;
        got = (rdq.size() > 0) ? rdq.pop_front() : 32'h7fff_ffff;
        check_val(tag, got, exp);
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all(input string pfx);
        rdq.delete();
        for (int a = 0; a < DEPTH; a++) send(OP_READ, a, 0);
        idle();
        wait_reads({pfx, "_cnt"}, DEPTH);
        for (int a = 0; a < DEPTH; a++) pop_check($sformatf("%s_%0d", pfx, a), int'(RV));
    endtask

    initial begin
        int n;
        int base;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 1);
        check_val("rst_ready", int'(op_ready), 0);
        check_val("rst_rd_valid", int'(rd_valid), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_rd_data", int'(rd_data), 0);

        // Init sweep length and contents
        reset = 1'b0;
        wait_not_busy(n);
        check_val("init_busy_cycles", n, DEPTH);
        check_val("init_ready", int'(op_ready), 1);
        read_all("init_word");

        // Write, accumulate, read back-to-back to one word
        repeat (3) tick();
        rdq.delete();
        send(OP_WRITE, 3, 10);
        send(OP_ACC, 3, -4);
        send(OP_READ, 3, 0);
        idle();
        check_val("lat_n1", int'(rd_valid), 0);
        tick();
        check_val("lat_n2", int'(rd_valid), 0);
        tick();
        check_val("lat_rd_valid", int'(rd_valid), 1);
        check_val("lat_rd_data", int'(rd_data), 6);
        tick();
        check_val("rd_valid_pulse", int'(rd_valid), 0);

        // Read-and-clear
        repeat (2) tick();
        rdq.delete();
        send(OP_WRITE, 1, 7);
        send(OP_RDCLR, 1, 0);
        send(OP_READ, 1, 0);
        idle();
        wait_reads("rdclr_cnt", 2);
        pop_check("rdclr_old", 7);
        pop_check("rdclr_after", int'(RV));
        repeat (3) tick();
        check_val("hold_rd_valid", int'(rd_valid), 0);
        check_val("hold_rd_data", int'(rd_data), int'(RV));

        // Positive overflow
        rdq.delete();
        base = ovf_cnt;
        send(OP_WRITE, 0, 120);
        send(OP_ACC, 0, 20);
        send(OP_READ, 0, 0);
        idle();
        wait_reads("povf_cnt", 1);
        pop_check("povf_data", c_exp_pos_ovf);
        check_val("povf_pulses", ovf_cnt - base, 1);

        // Negative overflow
        repeat (2) tick();
        rdq.delete();
        base = ovf_cnt;
        send(OP_WRITE, 4, -120);
        send(OP_ACC, 4, -20);
        send(OP_READ, 4, 0);
        idle();
        wait_reads("novf_cnt", 1);
        pop_check("novf_data", c_exp_neg_ovf);
        check_val("novf_pulses", ovf_cnt - base, 1);

        // Dependency two ops apart, with an unrelated op between them
        repeat (2) tick();
        rdq.delete();
        base = ovf_cnt;
        send(OP_WRITE, 5, 1);
        send(OP_WRITE, 6, 2);
        send(OP_ACC, 5, 3);
        send(OP_ACC, 6, -3);
        send(OP_READ, 5, 0);
        send(OP_READ, 6, 0);
        idle();
        wait_reads("gap_cnt", 2);
        pop_check("gap_a5", 4);
        pop_check("gap_a6", -1);
        check_val("gap_no_ovf", ovf_cnt - base, 0);

        // init_req during continuous accumulate traffic
        repeat (2) tick();
        for (int k = 0; k < 8; k++) begin
            init_req = (k == 3);
            send(OP_ACC, k % DEPTH, 1);
            init_req = 1'b0;
            if (k == 3) begin
                check_val("ireq_ready_drop", int'(op_ready), 0);
                check_val("ireq_busy", int'(busy), 1);
            end
        end
        idle();
        wait_not_busy(n);
        check_val("ireq_sweep_done", int'(busy), 0);
        read_all("ireq_word");

        // Reset with a write in flight
        repeat (2) tick();
        rdq.delete();
        send(OP_WRITE, 2, 9);
        idle();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_val("rrst_rd_valid", int'(rd_valid), 0);
        check_val("rrst_busy", int'(busy), 1);
        reset = 1'b0;
        // Restart the sweep while it is already running
        repeat (3) tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        wait_not_busy(n);
        check_val("restart_busy_cycles", n, DEPTH);
        check_val("rrst_no_reads", rdq.size(), 0);
        send(OP_READ, 2, 0);
        idle();
        wait_reads("rrst_cnt", 1);
        pop_check("rrst_a2", int'(RV));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule : tb_sram_accum

`default_nettype wire

// File: doc/sram_accum.md
SRAM_ACCUM -- requirements
Module: sram_accum

Interface
REQ-001 WIDTH, 32, bits per signed word.
REQ-002 DEPTH, 256, number of words; ADDR_W = $clog2(DEPTH).
REQ-003 RESET_VALUE, 0, value written to every word by the init sweep.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 init_req  in  1  single-cycle pulse that restarts the init sweep.
REQ-007 op_valid  in  1  operation request.
REQ-008 op_ready  out  1  block can accept an operation this cycle.
REQ-009 op_code  in  2  op_t: OP_WRITE=0, OP_ACC=1, OP_READ=2, OP_RDCLR=3.
REQ-010 op_addr  in  ADDR_W  target word address.
REQ-011 op_data  in  WIDTH  signed write data or addend.
REQ-012 rd_valid  out  1  rd_data is valid this cycle.
REQ-013 rd_data  out  WIDTH  signed read result.
REQ-014 ovf  out  1  pulse: OP_ACC result overflowed.
REQ-015 busy  out  1  init sweep in progress.

Function
REQ-016 FSM states INIT and RUN; reset deassertion enters INIT.
REQ-017 INIT: one address per cycle from 0 to DEPTH-1 gets RESET_VALUE; after DEPTH-1, go to RUN; busy=1 and op_ready=0 throughout.
REQ-018 RUN: op_ready=1; an op is accepted when op_valid && op_ready.
REQ-019 init_req in RUN: go to INIT at address 0; in-flight ops complete first, and new ops are refused from the following cycle.
REQ-020 init_req in INIT: restart the sweep at address 0.
REQ-021 Pipeline: accept at cycle N; array read N+1; compute, writeback and registered outputs at N+2.
REQ-022 Throughput one op per cycle; no stalls in RUN.
REQ-023 OP_WRITE: mem[addr] := op_data; no rd_valid.
REQ-024 OP_ACC: mem[addr] := mem[addr] + op_data; no rd_valid.
REQ-025 OP_READ: rd_valid=1, rd_data = mem[addr] at N+2.
REQ-026 OP_RDCLR: rd_valid=1, rd_data = old mem[addr]; mem[addr] := RESET_VALUE.
REQ-027 Hazard forwarding: an op at N+1 or N+2 to the same address as the op at N sees the op-N result, i.e. results are identical to sequential execution.
REQ-028 Addition is computed at WIDTH+1 bits; overflow occurs when the result falls outside the signed WIDTH range.
REQ-029 rd_valid and ovf are single-cycle pulses; rd_data holds its last value when rd_valid=0.

Reset
REQ-030 reset asserted: FSM=INIT, sweep address 0, pipeline valid bits cleared, rd_valid=0, ovf=0, rd_data=0, op_ready=0, busy=1.
REQ-031 Memory array is not cleared by reset; the INIT sweep clears it.
REQ-032 reset mid-operation: in-flight ops are discarded; no writeback.

Configuration
REQ-033 SRAM_ACCUM_SAT_EN defined: OP_ACC overflow clamps to the signed WIDTH max or min and ovf=1.
REQ-034 SRAM_ACCUM_SAT_EN undefined: OP_ACC wraps modulo 2^WIDTH and ovf=1 still pulses on overflow.

Structure
REQ-035 Package sram_pkg holds op_t and the OP_* encodings.
REQ-036 Sub-module sram_accum_array: storage only, one synchronous read port and one write port, parameters WIDTH and DEPTH.
REQ-037 FSM, pipeline, forwarding and arithmetic live in sram_accum.

Verification
REQ-038 Release reset with DEPTH=8 and RESET_VALUE=5 -> busy=1 for exactly 8 cycles, then op_ready=1; OP_READ of each address returns 5.
REQ-039 Send OP_WRITE a=3 d=10, then OP_ACC a=3 d=-4 and OP_READ a=3 on consecutive cycles -> rd_data=6, rd_valid 2 cycles after the read is accepted.
REQ-040 Send OP_WRITE a=1 d=7 followed by OP_RDCLR a=1 and OP_READ a=1 -> rd_data=7, then rd_data=RESET_VALUE.
REQ-041 WIDTH=8: OP_WRITE 120, then OP_ACC +20 -> ovf=1; READ gives 127 with SAT_EN, -116 without.
REQ-042 Assert init_req during continuous OP_ACC traffic -> in-flight ops retire, op_ready drops, and all words read RESET_VALUE after the sweep.
REQ-043 Assert reset two cycles after an OP_WRITE a=2 d=9 -> no rd_valid, and the post-init READ a=2 returns RESET_VALUE.
